// File: rtl/seletor_coluna_pkg.sv
// Shared encodings and parameter helpers for the column selector.
package seletor_coluna_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HOLD     = 2'd2
    } estado_t;

    typedef enum logic [1:0] {
        CMD_LEFT    = 2'd0,
        CMD_RIGHT   = 2'd1,
        CMD_CONFIRM = 2'd2
    } cmd_t;

    // One counter width serves both the debounce and the repeat timers.
    function automatic int cnt_width(input int deb_cycles, input int repeat_cycles);
        int maior;
        maior = (deb_cycles > repeat_cycles) ? deb_cycles : repeat_cycles;
        return $clog2(maior + 1);
    endfunction

    function automatic bit params_ok(input int num_cols, input int init_col,
                                     input int deb_cycles, input int repeat_cycles);
        return (num_cols >= 2) && (num_cols <= 8) &&
               (init_col >= 0) && (init_col < num_cols) &&
               (deb_cycles >= 2) && (repeat_cycles >= 1);
    endfunction

endpackage

// File: rtl/sincronizador_botao.sv
// Two-flop synchronizer for one raw push-button; 2-cycle latency, no backpressure.
module sincronizador_botao (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/modulo_seletor_coluna.sv
// Debounced left/right/confirm buttons drive a wrapping column cursor; pin-to-mdc is 2+DEB_CYCLES+1 cycles,
// no backpressure. SELETOR_AUTO_REPEAT_EN adds a held-button auto-repeat of left/right.
module modulo_seletor_coluna
    import seletor_coluna_pkg::*;
#(
    parameter int NUM_COLS      = 8,
    parameter int INIT_COL      = 0,
    parameter int DEB_CYCLES    = 50000,
    parameter int REPEAT_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_confirm,
    output logic [2:0] mdc,
    output logic       confirm,
    output logic       busy
);

    localparam int            CW       = cnt_width(DEB_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [2:0]    LAST_COL = 3'(NUM_COLS - 1);
    localparam logic [2:0]    INIT_MDC = 3'(INIT_COL);

    if (!params_ok(NUM_COLS, INIT_COL, DEB_CYCLES, REPEAT_CYCLES)) begin : g_params_invalidos
        $error("modulo_seletor_coluna: illegal NUM_COLS/INIT_COL/DEB_CYCLES/REPEAT_CYCLES");
    end

    logic s_left;
    logic s_right;
    logic s_confirm;

    sincronizador_botao u_sinc_left (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_left),
        .sync_o (s_left)
    );

    sincronizador_botao u_sinc_right (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_right),
        .sync_o (s_right)
    );

    sincronizador_botao u_sinc_confirm (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_confirm),
        .sync_o (s_confirm)
    );

    estado_t       state_q;
    cmd_t          cmd_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    mdc_q;
    logic          confirm_q;
    logic          busy_q;

    logic          exactly_one;
    logic          any_btn;
    logic          s_cmd;
    cmd_t          cmd_sel;
    logic [CW-1:0] cnt_d;

    assign exactly_one = (s_left ^ s_right ^ s_confirm) & ~(s_left & s_right & s_confirm);
    assign any_btn     = s_left | s_right | s_confirm;
    assign cmd_sel     = s_left ? CMD_LEFT : (s_right ? CMD_RIGHT : CMD_CONFIRM);
    assign cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        s_cmd = 1'b0;
        case (cmd_q)
            CMD_LEFT:    s_cmd = s_left;
            CMD_RIGHT:   s_cmd = s_right;
            CMD_CONFIRM: s_cmd = s_confirm;
            default:     s_cmd = 1'b0;
        endcase
    end

    // Wrap rules keep mdc inside 0..NUM_COLS-1; confirm leaves the cursor alone.
    function automatic logic [2:0] passo(input logic [2:0] col, input cmd_t cmd);
        if (cmd == CMD_LEFT)
            return (col == 3'd0) ? LAST_COL : col - 3'd1;
        else if (cmd == CMD_RIGHT)
            return (col == LAST_COL) ? 3'd0 : col + 3'd1;
        else
            return col;
    endfunction

`ifdef SELETOR_AUTO_REPEAT_EN
    localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);
    logic [CW-1:0] rpt_q;
    logic [CW-1:0] rpt_d;
    assign rpt_d = (rpt_q == CNT_MAX) ? rpt_q : rpt_q + CNT_ONE;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= CMD_LEFT;
            cnt_q     <= '0;
            mdc_q     <= INIT_MDC;
            confirm_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SELETOR_AUTO_REPEAT_EN
            rpt_q     <= '0;
`endif
        end else begin
            confirm_q <= 1'b0;
            if (!enable) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
`ifdef SELETOR_AUTO_REPEAT_EN
                rpt_q   <= '0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (exactly_one) begin
                            cmd_q   <= cmd_sel;
                            cnt_q   <= '0;
                            state_q <= S_DEBOUNCE;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (!s_cmd) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else if (cnt_q == DEB_LAST) begin
                            mdc_q     <= passo(mdc_q, cmd_q);
                            confirm_q <= (cmd_q == CMD_CONFIRM);
                            cnt_q     <= '0;
                            state_q   <= S_HOLD;
`ifdef SELETOR_AUTO_REPEAT_EN
                            rpt_q     <= '0;
`endif
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    S_HOLD: begin
                        // Release must be seen on every button, not just the one that was accepted.
                        if (any_btn) begin
                            cnt_q <= '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
`ifdef SELETOR_AUTO_REPEAT_EN
                        if (s_cmd && (cmd_q != CMD_CONFIRM)) begin
                            if (rpt_q == RPT_LAST) begin
                                mdc_q <= passo(mdc_q, cmd_q);
                                rpt_q <= '0;
                            end else begin
                                rpt_q <= rpt_d;
                            end
                        end else begin
                            rpt_q <= '0;
                        end
`endif
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mdc     = mdc_q;
    assign confirm = confirm_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_modulo_seletor_coluna.sv
// Scoreboard bench: two selectors (8 and 5 columns) share stimulus; press-level model predicts events.
module tb_modulo_seletor_coluna;

    localparam int DEB = 4;
    localparam int RPT = 8;
    localparam int N8  = 8;
    localparam int N5  = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       btn_left;
    logic       btn_right;
    logic       btn_confirm;
    logic [2:0] mdc8, mdc5;
    logic       conf8, conf5, busy8, busy5;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    modulo_seletor_coluna #(.NUM_COLS(N8), .INIT_COL(0), .DEB_CYCLES(DEB), .REPEAT_CYCLES(RPT)) dut8 (
        .clk(clk), .reset(reset), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_confirm(btn_confirm),
        .mdc(mdc8), .confirm(conf8), .busy(busy8)
    );

    modulo_seletor_coluna #(.NUM_COLS(N5), .INIT_COL(0), .DEB_CYCLES(DEB), .REPEAT_CYCLES(RPT)) dut5 (
        .clk(clk), .reset(reset), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_confirm(btn_confirm),
        .mdc(mdc5), .confirm(conf5), .busy(busy5)
    );

    typedef struct {
        int cyc;
        bit is_conf;
        int m8;
        int m5;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  model8   = 0;
    int  model5   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: any cursor change or confirm pulse must match the next predicted event.
    logic [2:0] prev8, prev5;
    always @(negedge clk) begin
        if (reset !== 1'b1 && (conf8 || conf5 || mdc8 !== prev8 || mdc5 !== prev5)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: cycle %0d mdc8=%0d mdc5=%0d conf8=%0d conf5=%0d, expected no event",
                         cyc, mdc8, mdc5, conf8, conf5);
            end else begin
                ev_t ev;
                ev = exp_q.pop_front();
                check("ev_cycle", cyc, ev.cyc);
                check("ev_mdc8", {29'd0, mdc8}, ev.m8);
                check("ev_mdc5", {29'd0, mdc5}, ev.m5);
                check("ev_conf8", {31'd0, conf8}, {31'd0, ev.is_conf});
                check("ev_conf5", {31'd0, conf5}, {31'd0, ev.is_conf});
            end
        end
        prev8 = mdc8;
        prev5 = mdc5;
    end

    // Button press of L cycles with mask {left,right,confirm}, then gap idle cycles.
    task automatic press(input logic [2:0] mask, input int len, input int gap);
        int  k;
        int  nrep;
        bit  single;
        ev_t ev;
        single = ($countones(mask) == 1);
        @(posedge clk); #1;
        k = cyc;
        // A press is accepted only if it is still high DEB+1 cycles after it rises.
        if (single && len >= DEB + 1) begin
            nrep = 0;
`ifdef SELETOR_AUTO_REPEAT_EN
            if (!mask[0]) nrep = (len - DEB - 1) / RPT;
`endif
            for (int j = 0; j <= nrep; j++) begin
                if (mask[2]) begin
                    model8 = (model8 + N8 - 1) % N8;
                    model5 = (model5 + N5 - 1) % N5;
                end else if (mask[1]) begin
                    model8 = (model8 + 1) % N8;
                    model5 = (model5 + 1) % N5;
                end
                ev.cyc     = k + DEB + 3 + RPT * j;
                ev.is_conf = mask[0];
                ev.m8      = model8;
                ev.m5      = model5;
                exp_q.push_back(ev);
            end
        end
        {btn_left, btn_right, btn_confirm} = mask;
        for (int i = 1; i <= len + gap; i++) begin
            @(posedge clk); #1;
            if (i == len) {btn_left, btn_right, btn_confirm} = 3'b000;
            if (i == 3 && single) begin
                check("busy8_active", {31'd0, busy8}, 1);
                check("busy5_active", {31'd0, busy5}, 1);
            end
        end
        check("busy8_idle", {31'd0, busy8}, 0);
        check("busy5_idle", {31'd0, busy5}, 0);
    endtask

    // Right press cut short in the debounce state by reset (use_reset=1) or enable=0.
    task automatic abort_press(input bit use_reset);
        {btn_left, btn_right, btn_confirm} = 3'b010;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 4) begin
                check("busy8_mid", {31'd0, busy8}, 1);
                btn_right = 1'b0;
                if (use_reset) reset = 1'b1;
                else enable = 1'b0;
            end
            if (i == 5 && !use_reset) check("busy8_disabled", {31'd0, busy8}, 0);
            if (i == 6 && use_reset) begin
                reset  = 1'b0;
                model8 = 0;
                model5 = 0;
            end
            if (i == 7 && !use_reset) enable = 1'b1;
        end
        check("abort_mdc8", {29'd0, mdc8}, model8);
        check("abort_mdc5", {29'd0, mdc5}, model5);
        check("abort_busy8", {31'd0, busy8}, 0);
        check("abort_busy5", {31'd0, busy5}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        btn_left    = 1'b0;
        btn_right   = 1'b0;
        btn_confirm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mdc8", {29'd0, mdc8}, 0);
        check("rst_mdc5", {29'd0, mdc5}, 0);
        check("rst_conf8", {31'd0, conf8}, 0);
        check("rst_busy8", {31'd0, busy8}, 0);
        reset = 1'b0;

        press(3'b010, 10, 10);          // 0 -> 1 after 7 cycles
        press(3'b100, 10, 10);          // 1 -> 0
        press(3'b100, 10, 10);          // wrap down to 7 / 4
        press(3'b010, 10, 10);          // wrap up to 0 / 0
        for (int i = 0; i < 5; i++) press(3'b010, 8, 9);   // 5-col wraps 4 -> 0
        press(3'b010, 2, 10);           // glitch
        press(3'b010, DEB, 10);         // one cycle short of acceptance
        press(3'b010, DEB + 1, 10);     // shortest accepted press
        press(3'b010, 100, 10);         // long hold
        press(3'b110, 20, 10);          // simultaneous presses ignored
        press(3'b111, 20, 10);
        press(3'b001, 10, 10);          // confirm pulse
        abort_press(1'b1);
        abort_press(1'b0);
        press(3'b010, DEB + 1 + 30, 10);

        for (int n = 0; n < 40; n++) begin
            logic [2:0] m;
            int         len;
            m   = 3'($urandom_range(1, 7));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 12));
            press(m, len, int'($urandom_range(8, 14)));
        end

        repeat (20) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
